// File: rtl/softmax_seq_ctrl_if.sv
// Handshake bundle between the softmax sequencer, its sample source and the exp stage.
interface softmax_seq_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int IDX_W      = 3
);
   logic                         start;
   logic                         in_valid;
   logic signed [DATA_WIDTH-1:0] in_data;
   logic                         in_ready;
   logic                         out_valid;
   logic signed [DATA_WIDTH:0]   out_data;
   logic [IDX_W-1:0]             out_idx;
   logic                         out_ready;
   logic signed [DATA_WIDTH-1:0] max_out;
   logic                         busy;
   logic                         done;

   modport master (
      output start, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, max_out, busy, done
   );

   modport slave (
      input  start, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, max_out, busy, done
   );
endinterface

// File: rtl/softmax_seq_ctrl.sv
// Softmax front end: buffers one N-sample vector, tracks its maximum, then streams x[i]-max.
module softmax_seq_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int N          = 8,
   parameter int IDX_W      = 3
) (
   input logic               clk,
   input logic               rst_n,
   softmax_seq_ctrl_if.slave sif
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   logic [1:0]                   state_q, state_d;
   logic [IDX_W-1:0]             ld_cnt_q, ld_cnt_d;
   logic [IDX_W-1:0]             drn_cnt_q, drn_cnt_d;
   logic signed [DATA_WIDTH-1:0] max_q, max_d;
   logic signed [DATA_WIDTH-1:0] bank_q [N];
   logic signed [DATA_WIDTH-1:0] bank_d [N];
   logic [N-1:0]                 bank_we;
   logic                         accept;
   logic                         drain_hs;
   logic signed [DATA_WIDTH-1:0] cur;
   logic signed [DATA_WIDTH:0]   cur_x;
   logic signed [DATA_WIDTH:0]   max_x;

   // Handshakes only count in their own state, so stray valid/ready elsewhere are inert.
   assign accept   = (state_q == S_LOAD)  && sif.in_valid;
   assign drain_hs = (state_q == S_DRAIN) && sif.out_ready;

   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      drn_cnt_d = drn_cnt_q;
      max_d     = max_q;
      case (state_q)
         S_IDLE: begin
            if (sif.start) begin
               state_d   = S_LOAD;
               ld_cnt_d  = '0;
               drn_cnt_d = '0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if ((ld_cnt_q == '0) || (sif.in_data > max_q)) max_d = sif.in_data;
               if (ld_cnt_q == LAST) state_d = S_DRAIN;
               else                  ld_cnt_d = ld_cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_hs) begin
               if (drn_cnt_q == LAST) state_d = S_DONE;
               else                   drn_cnt_d = drn_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ld_cnt_q  <= '0;
         drn_cnt_q <= '0;
         max_q     <= '0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         drn_cnt_q <= drn_cnt_d;
         max_q     <= max_d;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_bank
      assign bank_we[k] = accept && (ld_cnt_q == IDX_W'(k));

      always_comb begin
         bank_d[k] = bank_q[k];
         if (bank_we[k]) bank_d[k] = sif.in_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) bank_q[k] <= '0;
         else        bank_q[k] <= bank_d[k];
      end
   end

   // One extra bit covers the full span min-max, so the subtraction never saturates.
   assign cur   = bank_q[drn_cnt_q];
   assign cur_x = {cur[DATA_WIDTH-1], cur};
   assign max_x = {max_q[DATA_WIDTH-1], max_q};

   assign sif.out_data  = cur_x - max_x;
   assign sif.out_idx   = drn_cnt_q;
   assign sif.out_valid = (state_q == S_DRAIN);
   assign sif.in_ready  = (state_q == S_LOAD);
   assign sif.busy      = (state_q != S_IDLE);
   assign sif.done      = (state_q == S_DONE);
   assign sif.max_out   = max_q;
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Self-checking bench for softmax_seq_ctrl with N=4, 16-bit samples.
module tb_softmax_seq_ctrl;
   localparam int DW = 16;
   localparam int NN = 4;
   localparam int IW = 2;

   typedef struct packed {
      logic [3:0][31:0] x;
      logic [31:0]      emax;
      logic [3:0][31:0] eout;
      logic [1:0]       vmode;
      logic [1:0]       rmode;
      logic             hold;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   softmax_seq_ctrl_if #(.DATA_WIDTH(DW), .IDX_W(IW)) sif ();

   softmax_seq_ctrl #(.DATA_WIDTH(DW), .N(NN), .IDX_W(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int a0, a1, a2, a3, input int m,
                               input int o0, o1, o2, o3,
                               input int vm, rm, input bit h);
      vec_t v;
      v.x[0] = a0; v.x[1] = a1; v.x[2] = a2; v.x[3] = a3;
      v.emax = m;
      v.eout[0] = o0; v.eout[1] = o1; v.eout[2] = o2; v.eout[3] = o3;
      v.vmode = 2'(vm); v.rmode = 2'(rm); v.hold = h;
      return v;
   endfunction

   // Reference model: max over the vector, then each sample minus that max.
   function automatic vec_t model(input int xs[4], input int vm, rm);
      int m;
      int o[4];
      m = xs[0];
      foreach (xs[i]) if (xs[i] > m) m = xs[i];
      foreach (xs[i]) o[i] = xs[i] - m;
      return mk(xs[0], xs[1], xs[2], xs[3], m, o[0], o[1], o[2], o[3], vm, rm, 1'b0);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  int'(sif.in_ready), 0);
      check({tag, "_out_valid"}, int'(sif.out_valid), 0);
      check({tag, "_out_data"},  int'(sif.out_data), 0);
      check({tag, "_out_idx"},   int'(sif.out_idx), 0);
      check({tag, "_max_out"},   int'(sif.max_out), 0);
      check({tag, "_busy"},      int'(sif.busy), 0);
      check({tag, "_done"},      int'(sif.done), 0);
   endtask

   // Starts a pass, loads the vector, drains it; if abort_at>=0 the caller resets mid-drain.
   task automatic run_vec(input vec_t v, input string tag, input int abort_at);
      int xs[4];
      int eo[4];
      int acc, got, cyc, stall;
      bit vv, rr;
      for (int i = 0; i < 4; i++) begin
         xs[i] = int'($signed(v.x[i]));
         eo[i] = int'($signed(v.eout[i]));
      end
      @(negedge clk);
      sif.start = 1'b0; sif.in_valid = 1'b1; sif.in_data = 16'h7fff; sif.out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_idle_in_ready"}, int'(sif.in_ready), 0);
      check({tag, "_idle_busy"}, int'(sif.busy), 0);
      sif.start = 1'b1; sif.in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_load_in_ready"}, int'(sif.in_ready), 1);
      check({tag, "_load_busy"}, int'(sif.busy), 1);
      if (!v.hold) sif.start = 1'b0;
      acc = 0; cyc = 0;
      while (acc < 4 && cyc < 200) begin
         case (v.vmode)
            2'd0:    vv = 1'b1;
            2'd1:    vv = (cyc % 2) == 0;
            default: vv = 1'($urandom % 2);
         endcase
         sif.in_valid = vv;
         sif.in_data  = vv ? 16'(xs[acc]) : 16'($urandom);
         if (vv && sif.in_ready) acc++;
         cyc++;
         @(negedge clk);
      end
      check({tag, "_accepts"}, acc, 4);
      sif.in_valid = v.hold;
      sif.in_data  = 16'($urandom);
      check({tag, "_ready_drop"}, int'(sif.in_ready), 0);
      check({tag, "_first_valid"}, int'(sif.out_valid), 1);
      check({tag, "_max"}, int'(sif.max_out), int'($signed(v.emax)));
      got = 0; cyc = 0; stall = 0;
      while (got < 4 && cyc < 200) begin
         if (got == abort_at) return;
         check({tag, "_valid"}, int'(sif.out_valid), 1);
         check({tag, "_idx"}, int'(sif.out_idx), got);
         check({tag, "_data"}, int'(sif.out_data), eo[got]);
         case (v.rmode)
            2'd0:    rr = 1'b1;
            2'd1:    rr = !(got == 1 && stall < 3);
            default: rr = 1'($urandom % 2);
         endcase
         if (!rr) stall++;
         sif.out_ready = rr;
         if (rr) got++;
         cyc++;
         @(negedge clk);
      end
      check({tag, "_handshakes"}, got, 4);
      sif.start = 1'b0; sif.in_valid = 1'b0; sif.out_ready = 1'b0;
      check({tag, "_done"}, int'(sif.done), 1);
      check({tag, "_done_busy"}, int'(sif.busy), 1);
      @(negedge clk);
      check({tag, "_done_drop"}, int'(sif.done), 0);
      check({tag, "_end_busy"}, int'(sif.busy), 0);
      check({tag, "_max_hold"}, int'(sif.max_out), int'($signed(v.emax)));
   endtask

   vec_t tbl[7];
   int   rx[4];

   initial begin
      sif.start = 1'b0; sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b0;
      tbl[0] = mk(3, -2, 7, 1,    7, -4, -9, 0, -6,    0, 0, 1'b0);
      tbl[1] = mk(3, -2, 7, 1,    7, -4, -9, 0, -6,    1, 0, 1'b0);
      tbl[2] = mk(3, -2, 7, 1,    7, -4, -9, 0, -6,    0, 1, 1'b0);
      tbl[3] = mk(-32768, 32767, -32768, 0,  32767, -65535, 0, -65535, -32767,  0, 0, 1'b0);
      tbl[4] = mk(5, 5, 5, 5,     5, 0, 0, 0, 0,       1, 1, 1'b0);
      tbl[5] = mk(-1, -5, -3, -1, -1, 0, -4, -2, 0,    0, 0, 1'b1);
      tbl[6] = mk(-7, 4, 4, -32768, 4, -11, 0, 0, -32772, 2, 2, 1'b1);

      #3;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 7; t++) run_vec(tbl[t], $sformatf("vec%0d", t), -1);

      // Reset in the middle of the drain, then a fresh pass must not see stale data.
      run_vec(tbl[3], "abort", 2);
      check("abort_pre_idx", int'(sif.out_idx), 2);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", int'(sif.busy), 0);
      check("post_rst_in_ready", int'(sif.in_ready), 0);
      run_vec(tbl[0], "fresh", -1);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 4; i++) begin
            case ($urandom % 5)
               0:       rx[i] = -32768;
               1:       rx[i] = 32767;
               2:       rx[i] = (i > 0) ? rx[i-1] : 0;
               default: rx[i] = int'($signed(16'($urandom)));
            endcase
         end
         run_vec(model(rx, 2, 2), $sformatf("rnd%0d", r), -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
